// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the keyboard clock/data, deframes 11-bit
// frames, and turns make/break scan codes into a held-key ASCII byte.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DAT,
  output logic [7:0] oSCAN,
  output logic       oSCAN_VALID,
  output logic [7:0] oASCII,
  output logic       oKEY_VALID,
  output logic       oERR,
  output logic [1:0] oSTATE
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Handshake: oSCAN_VALID/oKEY_VALID/oERR are single-cycle strobes with no ready;
  // oSCAN and oASCII are stable between strobes.
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    scan_q, scan_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          scan_valid_q, scan_valid_d;
  logic          key_valid_q, key_valid_d;
  logic          err_q, err_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;

  logic          fall, sample, accept;
  logic [8:0]    map;

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign sample = dat_sync_q[1];

  function automatic logic [8:0] map_key(input logic [7:0] code);
    case (code)
      8'h15:   map_key = {1'b1, 8'h51};
      8'h1D:   map_key = {1'b1, 8'h57};
      8'h24:   map_key = {1'b1, 8'h45};
      8'h2D:   map_key = {1'b1, 8'h52};
      8'h1C:   map_key = {1'b1, 8'h41};
      8'h1B:   map_key = {1'b1, 8'h53};
      8'h23:   map_key = {1'b1, 8'h44};
      8'h29:   map_key = {1'b1, 8'h20};
      default: map_key = 9'h000;
    endcase
  endfunction

  assign map = map_key(shift_q);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    tmo_d        = '0;
    scan_d       = scan_q;
    ascii_d      = ascii_q;
    brk_d        = brk_q;
    ext_d        = ext_q;
    scan_valid_d = 1'b0;
    key_valid_d  = 1'b0;
    err_d        = 1'b0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fall && !sample) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          par_err_d = 1'b0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          if (!(^{shift_q, sample})) par_err_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (!sample || par_err_q) err_d = 1'b1;
          else accept = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Mid-frame watchdog: abandon the frame if the keyboard stops clocking.
    if (state_q != S_IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = S_IDLE;
        bit_cnt_d = 3'd0;
        shift_d   = 8'h00;
        par_err_d = 1'b0;
        err_d     = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (accept) begin
      scan_d       = shift_q;
      scan_valid_d = 1'b1;
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        if (map[8] && map[7:0] == ascii_q) ascii_d = 8'h00;
        brk_d = 1'b0;
      end else if (map[8]) begin
        ascii_d     = map[7:0];
        key_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      clk_prev_q   <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_err_q    <= 1'b0;
      tmo_q        <= '0;
      scan_q       <= 8'h00;
      ascii_q      <= 8'h00;
      scan_valid_q <= 1'b0;
      key_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], iPS2_CLK};
      dat_sync_q   <= {dat_sync_q[0], iPS2_DAT};
      clk_prev_q   <= clk_sync_q[1];
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      tmo_q        <= tmo_d;
      scan_q       <= scan_d;
      ascii_q      <= ascii_d;
      scan_valid_q <= scan_valid_d;
      key_valid_q  <= key_valid_d;
      err_q        <= err_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
    end
  end

  assign oSCAN       = scan_q;
  assign oSCAN_VALID = scan_valid_q;
  assign oASCII      = ascii_q;
  assign oKEY_VALID  = key_valid_q;
  assign oERR        = err_q;
  assign oSTATE      = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: bit-banged PS/2 frames, pulse counters
// and hand-computed expected scan/ASCII values.
module tb_ps2_key_decoder;

  logic       clk, rst_n, ps2_clk, ps2_dat;
  logic [7:0] scan, ascii;
  logic       scan_valid, key_valid, err;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int scan_cnt = 0, key_cnt = 0, err_cnt = 0, key_alone = 0;
  int b_scan, b_key, b_err, b_alone;

  ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iPS2_CLK(ps2_clk), .iPS2_DAT(ps2_dat),
    .oSCAN(scan), .oSCAN_VALID(scan_valid), .oASCII(ascii),
    .oKEY_VALID(key_valid), .oERR(err), .oSTATE(state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge of the system clock
  always @(negedge clk) begin
    if (scan_valid) scan_cnt++;
    if (key_valid) key_cnt++;
    if (err) err_cnt++;
    if (key_valid && !scan_valid) key_alone++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic snap();
    b_scan = scan_cnt; b_key = key_cnt; b_err = err_cnt; b_alone = key_alone;
  endtask

  // Driver tasks
  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_cyc(3);
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop_bit);
    ps2_dat = 1'b1;
    wait_cyc(5);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    wait_cyc(3);
    check("rst_scan", scan, 8'h00);
    check("rst_ascii", ascii, 8'h00);
    check("rst_pulses", {scan_valid, key_valid, err}, 3'b000);
    rst_n = 1'b1;
    wait_cyc(5);

    // Single make of Q
    snap();
    send_frame(8'h15, 1'b0, 1'b1);
    check("q_scan", scan, 8'h15);
    check("q_ascii", ascii, 8'h51);
    check("q_scan_pulses", scan_cnt - b_scan, 1);
    check("q_key_pulses", key_cnt - b_key, 1);
    check("q_key_with_scan", key_alone - b_alone, 0);
    check("q_no_err", err_cnt - b_err, 0);

    // Press and release W
    snap();
    send_frame(8'h1D, 1'b0, 1'b1);
    check("w_ascii", ascii, 8'h57);
    send_frame(8'hF0, 1'b0, 1'b1);
    check("f0_scan", scan, 8'hF0);
    check("f0_ascii_held", ascii, 8'h57);
    send_frame(8'h1D, 1'b0, 1'b1);
    check("w_rel_ascii", ascii, 8'h00);
    check("w_scan_pulses", scan_cnt - b_scan, 3);
    check("w_key_pulses", key_cnt - b_key, 1);

    // Parity error on E
    snap();
    send_frame(8'h24, 1'b1, 1'b1);
    check("par_err_pulses", err_cnt - b_err, 1);
    check("par_scan_kept", scan, 8'h1D);
    check("par_ascii_kept", ascii, 8'h00);
    check("par_no_valid", (scan_cnt - b_scan) + (key_cnt - b_key), 0);

    // Extended code is ignored, then Q decodes
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    check("ext_ascii", ascii, 8'h00);
    check("ext_scan", scan, 8'h75);
    send_frame(8'h15, 1'b0, 1'b1);
    check("after_ext_ascii", ascii, 8'h51);

    // Last key wins; releasing an earlier key keeps the newer one
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1B, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("last_key_wins", ascii, 8'h53);

    // Unmapped make and a bad stop bit
    snap();
    send_frame(8'h5A, 1'b0, 1'b1);
    check("unmapped_ascii", ascii, 8'h53);
    check("unmapped_scan", scan, 8'h5A);
    check("unmapped_no_key", key_cnt - b_key, 0);
    snap();
    send_frame(8'h23, 1'b0, 1'b0);
    check("stop_err_pulses", err_cnt - b_err, 1);
    check("stop_err_ascii", ascii, 8'h53);
    check("stop_err_scan", scan, 8'h5A);

    // Timeout after start + 4 data bits; last edge driven here and timed
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_dat = 1'b1;
    wait_cyc(3);
    ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 5) ps2_clk = 1'b1;
      if (err && lat == 0) lat = k;
    end
    // 3 cycles of sync/edge latency plus 100 idle cycles
    check("tmo_latency", lat, 103);
    check("tmo_err_pulses", err_cnt - b_err, 1);
    send_frame(8'h2D, 1'b0, 1'b1);
    check("tmo_next_ascii", ascii, 8'h52);
    check("tmo_next_scan", scan, 8'h2D);

    // Reset in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("mid_rst_scan", scan, 8'h00);
    check("mid_rst_ascii", ascii, 8'h00);
    check("mid_rst_pulses", {scan_valid, key_valid, err}, 3'b000);
    rst_n = 1'b1;
    wait_cyc(5);
    send_frame(8'h29, 1'b0, 1'b1);
    check("post_rst_ascii", ascii, 8'h20);
    check("post_rst_scan", scan, 8'h29);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
